// File: rtl/sprite_animator.sv
// Sprite box test, sprite-sheet ROM addressing and per-state frame sequencing for the pixel path.
// Pixel to colour latency is ROM_LATENCY+2 clocks. There is no backpressure: the engine accepts one pixel per clock.
module sprite_animator #(
  parameter int                    SPRITE_W          = 150,
  parameter int                    SPRITE_H          = 157,
  parameter int                    NUM_STATES        = 6,
  parameter int                    FRAMES            = 4,
  parameter int                    HOLD              = 2,
  parameter logic [NUM_STATES-1:0] LOOP_MASK         = 6'b000111,
  parameter int                    ROM_LATENCY       = 1,
  parameter int                    ADDR_W            = 20,
  parameter logic [7:0]            TRANSPARENT_COLOR = 8'hE3,
  parameter logic [7:0]            DEFAULT_COLOR     = 8'h25,
  localparam int                   FW                = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        current_pixel_x,
  input  logic [9:0]        current_pixel_y,
  input  logic [9:0]        posx,
  input  logic [9:0]        posy,
  input  logic [3:0]        currentstate,
  input  logic              flip,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        data,
  output logic              visible_flag,
  output logic [FW-1:0]     anim_frame,
  output logic              anim_done
);

  localparam int                 HW         = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [3:0]         NS_L       = 4'(NUM_STATES);
  localparam logic [FW-1:0]      LAST_FRAME = FW'(FRAMES - 1);
  localparam logic [HW-1:0]      LAST_HOLD  = HW'(HOLD - 1);
  localparam logic [ADDR_W-1:0]  FRAME_SZ   = ADDR_W'(SPRITE_W * SPRITE_H);
  localparam logic [15:0]        LOOP_EXT   = 16'(LOOP_MASK);

  logic [3:0]    state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          done_q, done_d;
  logic          st_ok, is_loop;

  assign st_ok   = (state_q < NS_L);
  assign is_loop = LOOP_EXT[state_q];

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (currentstate != state_q) begin
      // a state change wins over a coincident frame_tick
      state_d = currentstate;
      frame_d = '0;
      hold_d  = '0;
    end else if (frame_tick) begin
      if (hold_q != LAST_HOLD) begin
        hold_d = hold_q + HW'(1);
      end else begin
        hold_d = '0;
        if (!st_ok) begin
          frame_d = '0;
        end else if (frame_q != LAST_FRAME) begin
          frame_d = frame_q + FW'(1);
          done_d  = !is_loop && (frame_d == LAST_FRAME);
        end else if (is_loop) begin
          frame_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      frame_q <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  // 11-bit box limits keep sprites near the right/bottom edge from wrapping to 0
  logic [10:0]       x_end, y_end;
  logic [9:0]        rx, ry, rx_m;
  logic              ins_c, inv_c;
  logic [ADDR_W-1:0] slot, addr_c;

  assign x_end  = {1'b0, posx} + 11'(SPRITE_W);
  assign y_end  = {1'b0, posy} + 11'(SPRITE_H);
  assign ins_c  = (current_pixel_x >= posx) && ({1'b0, current_pixel_x} < x_end) &&
                  (current_pixel_y >= posy) && ({1'b0, current_pixel_y} < y_end);
  assign inv_c  = (currentstate >= NS_L);
  assign rx     = current_pixel_x - posx;
  assign ry     = current_pixel_y - posy;
  assign rx_m   = flip ? (10'(SPRITE_W - 1) - rx) : rx;
  assign slot   = ADDR_W'(state_q) * ADDR_W'(FRAMES) + ADDR_W'(frame_q);
  assign addr_c = slot * FRAME_SZ + ADDR_W'(ry) * ADDR_W'(SPRITE_W) + ADDR_W'(rx_m);

  logic [ADDR_W-1:0]      rom_addr_q;
  logic                   ins_q, inv_q;
  logic [ROM_LATENCY-1:0] ins_sr_q, inv_sr_q;
  logic [7:0]             data_q;
  logic                   vis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      ins_q      <= 1'b0;
      inv_q      <= 1'b0;
      ins_sr_q   <= '0;
      inv_sr_q   <= '0;
      data_q     <= '0;
      vis_q      <= 1'b0;
    end else begin
      rom_addr_q  <= (ins_c && !inv_c && st_ok) ? addr_c : '0;
      ins_q       <= ins_c;
      inv_q       <= inv_c;
      // qualifiers ride alongside the ROM read so they meet rom_data
      ins_sr_q[0] <= ins_q;
      inv_sr_q[0] <= inv_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        ins_sr_q[i] <= ins_sr_q[i-1];
        inv_sr_q[i] <= inv_sr_q[i-1];
      end
      if (!ins_sr_q[ROM_LATENCY-1]) begin
        data_q <= '0;
        vis_q  <= 1'b0;
      end else if (inv_sr_q[ROM_LATENCY-1]) begin
        data_q <= DEFAULT_COLOR;
        vis_q  <= 1'b1;
      end else begin
        data_q <= rom_data;
        vis_q  <= (rom_data != TRANSPARENT_COLOR);
      end
    end
  end

  assign rom_addr     = rom_addr_q;
  assign data         = data_q;
  assign visible_flag = vis_q;
  assign anim_frame   = frame_q;
  assign anim_done    = done_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed cases plus randomized traffic against a tick-count reference model.
module tb_sprite_animator;
  localparam int         W    = 150;
  localparam int         H    = 157;
  localparam int         NS   = 6;
  localparam int         FR   = 4;
  localparam int         HOLD = 2;
  localparam logic [5:0] LOOP = 6'b000111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  px = '0, py = '0, posx = '0, posy = '0;
  logic [3:0]  cs = '0;
  logic        flip = 1'b0, tick = 1'b0;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  data;
  logic        vis;
  logic [1:0]  anim_frame;
  logic        anim_done;
  logic [7:0]  key = 8'h1F;

  always #5 clk = ~clk;

  sprite_animator dut (
    .clk(clk), .rst_n(rst_n),
    .current_pixel_x(px), .current_pixel_y(py),
    .posx(posx), .posy(posy),
    .currentstate(cs), .flip(flip), .frame_tick(tick),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .data(data), .visible_flag(vis),
    .anim_frame(anim_frame), .anim_done(anim_done)
  );

  function automatic logic [7:0] rom_f(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ key;
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct packed { logic [19:0] addr; logic [1:0] fr; logic done; } a_t;
  typedef struct packed { logic [7:0] d; logic v; } p_t;
  a_t aq[$];
  p_t pq[$];
  logic       stim_vld = 1'b0;
  logic [2:0] vp;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) vp <= '0;
    else        vp <= {vp[1:0], stim_vld};

  always @(negedge clk) begin
    a_t ea;
    p_t ep;
    if (rst_n) begin
      if (vp[0]) begin
        if (aq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL addr_queue_underflow: got empty, expected entry");
        end else begin
          ea = aq.pop_front();
          check("sb_rom_addr", rom_addr, ea.addr);
          check("sb_anim_frame", anim_frame, ea.fr);
          check("sb_anim_done", anim_done, ea.done);
        end
      end
      if (vp[2]) begin
        if (pq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pix_queue_underflow: got empty, expected entry");
        end else begin
          ep = pq.pop_front();
          check("sb_data", data, ep.d);
          check("sb_visible", vis, ep.v);
        end
      end
    end
  end

  // reference animation: frame follows from ticks seen since the last state change
  int mstate = 0;
  int mticks = 0;

  function automatic int mframe(input int st, input int t);
    int f;
    if (st >= NS) return 0;
    f = t / HOLD;
    if (LOOP[st]) return f % FR;
    return (f > FR - 1) ? FR - 1 : f;
  endfunction

  // one clock: drive inputs at negedge, predict, consume the posedge, return at posedge+1
  task automatic step(input logic v, input logic [9:0] x, input logic [9:0] y, input logic tk);
    int st0, fr0, fr1, rx, ry;
    logic ins;
    logic [19:0] ea;
    a_t a;
    p_t p;
    @(negedge clk);
    px = x; py = y; tick = tk; stim_vld = v;
    st0 = mstate;
    fr0 = mframe(mstate, mticks);
    ins = (int'(x) >= int'(posx)) && (int'(x) < int'(posx) + W) &&
          (int'(y) >= int'(posy)) && (int'(y) < int'(posy) + H);
    rx = int'(x) - int'(posx);
    ry = int'(y) - int'(posy);
    if (flip) rx = W - 1 - rx;
    ea = '0;
    if (ins && int'(cs) < NS && st0 < NS) ea = 20'((st0 * FR + fr0) * W * H + ry * W + rx);
    if (!ins)              p = '{d: 8'h00, v: 1'b0};
    else if (int'(cs) >= NS) p = '{d: 8'h25, v: 1'b1};
    else begin
      p.d = rom_f(ea);
      p.v = (p.d != 8'hE3);
    end
    if (int'(cs) != mstate) begin
      mstate = int'(cs);
      mticks = 0;
    end else if (tk) begin
      mticks++;
    end
    fr1 = mframe(mstate, mticks);
    a.addr = ea;
    a.fr   = 2'(fr1);
    a.done = (mstate == st0) && (mstate < NS) && !LOOP[mstate] && (fr0 != FR - 1) && (fr1 == FR - 1);
    if (v) begin
      aq.push_back(a);
      pq.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pix_check(input string nm, input logic [9:0] x, input logic [9:0] y,
                           input logic [19:0] ea, input logic [7:0] ed, input logic ev);
    step(1'b1, x, y, 1'b0);
    check({nm, "_addr"}, rom_addr, ea);
    step(1'b0, x, y, 1'b0);
    step(1'b0, x, y, 1'b0);
    check({nm, "_data"}, data, ed);
    check({nm, "_vis"}, vis, ev);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    tick = 1'b0;
    stim_vld = 1'b0;
    #1;
    check("rst_rom_addr", rom_addr, 0);
    check("rst_data", data, 0);
    check("rst_vis", vis, 0);
    check("rst_anim_frame", anim_frame, 0);
    check("rst_anim_done", anim_done, 0);
    aq.delete();
    pq.delete();
    mstate = 0;
    mticks = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  int seq[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
  logic [9:0] rx_t, ry_t;

  initial begin
    posx = 10'd100; posy = 10'd50;
    @(posedge clk);
    do_reset();
    step(1'b0, 10'd0, 10'd0, 1'b0);
    check("post_rst_frame", anim_frame, 0);

    pix_check("p100_50", 10'd100, 10'd50, 20'd0, 8'h1F, 1'b1);
    pix_check("p249_206", 10'd249, 10'd206, 20'd23549, 8'hB9, 1'b1);
    pix_check("p250_50", 10'd250, 10'd50, 20'd0, 8'h00, 1'b0);
    flip = 1'b1;
    pix_check("flip", 10'd100, 10'd50, 20'd149, 8'h8A, 1'b1);
    flip = 1'b0;
    key = 8'hE3;
    pix_check("transp", 10'd100, 10'd50, 20'd0, 8'hE3, 1'b0);
    key = 8'h1F;
    posx = 10'd1000;
    pix_check("edge_in", 10'd1010, 10'd60, 20'd1510, 8'hFC, 1'b1);
    pix_check("edge_out", 10'd5, 10'd60, 20'd0, 8'h00, 1'b0);
    posx = 10'd100;
    cs = 4'd9;
    step(1'b0, 10'd100, 10'd50, 1'b0);
    pix_check("bad_state", 10'd100, 10'd50, 20'd0, 8'h25, 1'b1);

    cs = 4'd1;
    step(1'b0, 10'd100, 10'd50, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 10'd100, 10'd50, 1'b1);
      check("loop_frame", anim_frame, 32'(seq[i]));
      if (i == 3) begin
        step(1'b1, 10'd100, 10'd50, 1'b0);
        check("loop_base_f2", rom_addr, 20'd141300);
      end
    end

    cs = 4'd3;
    step(1'b0, 10'd100, 10'd50, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 10'd100, 10'd50, 1'b1);
      check("oneshot_frame", anim_frame, (i < 6) ? 32'((i + 1) / 2) : 32'd3);
      check("oneshot_done", anim_done, (i == 5) ? 32'd1 : 32'd0);
    end
    cs = 4'd0;
    step(1'b1, 10'd100, 10'd50, 1'b1);
    check("chg_tick_frame", anim_frame, 0);
    step(1'b1, 10'd100, 10'd50, 1'b1);
    check("chg_hold_frame", anim_frame, 0);
    step(1'b1, 10'd100, 10'd50, 1'b1);
    check("chg_adv_frame", anim_frame, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        posx = 10'($urandom);
        posy = 10'($urandom_range(0, 600));
      end
      if ($urandom_range(0, 59) == 0) cs = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) flip = ~flip;
      rx_t = 10'(int'(posx) + int'($urandom_range(0, W + 19)) - 10);
      ry_t = 10'(int'(posy) + int'($urandom_range(0, H + 19)) - 10);
      step(1'b1, rx_t, ry_t, ($urandom_range(0, 5) == 0));
    end

    do_reset();
    step(1'b0, 10'd0, 10'd0, 1'b0);
    check("mid_rst_frame", anim_frame, 0);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 29) == 0) cs = 4'($urandom_range(0, 9));
      rx_t = 10'(int'(posx) + int'($urandom_range(0, W + 19)) - 10);
      ry_t = 10'(int'(posy) + int'($urandom_range(0, H + 19)) - 10);
      step(1'b1, rx_t, ry_t, ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 3; i++) step(1'b0, px, py, 1'b0);
    @(negedge clk);
    #1;
    check("drain_addr_q", aq.size(), 0);
    check("drain_pix_q", pq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
